// File: rtl/dot_acc_seq.sv
// Job sequencer and scale-aligning accumulator for the block-scaled dot-product engine.
// Collects i_len (value, scale) chunk results and emits one aligned, renormalised job result.
module dot_acc_seq #(
    parameter int dp_width = 21,
    parameter int acc_w    = 24,
    parameter int len_w    = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [len_w-1:0]           i_len,
    output logic                       o_busy,
    input  logic                       i_dp_valid,
    output logic                       o_dp_ready,
    input  logic signed [dp_width-1:0] i_dp,
    input  logic [7:0]                 i_scale,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic signed [acc_w-1:0]    o_res,
    output logic [7:0]                 o_res_scale,
    output logic                       o_ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [acc_w-1:0] MAX_V = {1'b0, {(acc_w-1){1'b1}}};
    localparam logic signed [acc_w-1:0] MIN_V = {1'b1, {(acc_w-1){1'b0}}};

    state_t                      state_q, state_d;
    logic [len_w-1:0]            rem_q, rem_d;
    logic                        stage_valid_q, stage_valid_d;
    logic signed [dp_width-1:0]  stage_dp_q, stage_dp_d;
    logic [7:0]                  stage_scale_q, stage_scale_d;
    logic                        first_q, first_d;
    logic signed [acc_w-1:0]     acc_q, acc_d;
    logic [7:0]                  scale_q, scale_d;
    logic                        ovf_q, ovf_d;

    logic                        accept;
    logic signed [acc_w-1:0]     in_ext;
    logic signed [acc_w-1:0]     acc_al;
    logic signed [acc_w-1:0]     in_al;
    logic [7:0]                  d;
    logic [7:0]                  big_scale;
    logic signed [acc_w:0]       sum;
    logic                        fits;

    // Arithmetic shift that saturates to the sign fill once the distance covers the whole word.
    function automatic logic signed [acc_w-1:0] ashr(input logic signed [acc_w-1:0] x,
                                                     input logic [7:0] sh);
        if (int'(sh) >= acc_w) begin
            ashr = {acc_w{x[acc_w-1]}};
        end else begin
            ashr = x >>> sh;
        end
    endfunction

    assign accept = i_dp_valid && (state_q == RUN) && (rem_q != '0);
    assign in_ext = acc_w'(stage_dp_q);

    always_comb begin
        if (stage_scale_q >= scale_q) begin
            d         = stage_scale_q - scale_q;
            big_scale = stage_scale_q;
            acc_al    = ashr(acc_q, d);
            in_al     = in_ext;
        end else begin
            d         = scale_q - stage_scale_q;
            big_scale = scale_q;
            acc_al    = acc_q;
            in_al     = ashr(in_ext, d);
        end
        sum  = {acc_al[acc_w-1], acc_al} + {in_al[acc_w-1], in_al};
        fits = (sum[acc_w] == sum[acc_w-1]);
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        stage_valid_d = 1'b0;
        stage_dp_d    = stage_dp_q;
        stage_scale_d = stage_scale_q;
        first_d       = first_q;
        acc_d         = acc_q;
        scale_d       = scale_q;
        ovf_d         = ovf_q;

        // Accumulate stage: consumes the beat staged on the previous edge.
        if (stage_valid_q) begin
            first_d = 1'b0;
            if (first_q) begin
                acc_d   = in_ext;
                scale_d = stage_scale_q;
            end else if (fits) begin
                acc_d   = sum[acc_w-1:0];
                scale_d = big_scale;
            end else if (big_scale == 8'hFF) begin
                acc_d   = sum[acc_w] ? MIN_V : MAX_V;
                scale_d = 8'hFF;
                ovf_d   = 1'b1;
            end else begin
                acc_d   = sum[acc_w:1];
                scale_d = big_scale + 8'd1;
            end
        end

        if (accept) begin
            stage_valid_d = 1'b1;
            stage_dp_d    = i_dp;
            stage_scale_d = i_scale;
            rem_d         = rem_q - len_w'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    acc_d   = '0;
                    scale_d = '0;
                    ovf_d   = 1'b0;
                    first_d = 1'b1;
                    if (i_len != '0) begin
                        rem_d   = i_len;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept && (rem_q == len_w'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (stage_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_dp_q    <= '0;
            stage_scale_q <= '0;
            first_q       <= 1'b0;
            acc_q         <= '0;
            scale_q       <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            stage_valid_q <= stage_valid_d;
            stage_dp_q    <= stage_dp_d;
            stage_scale_q <= stage_scale_d;
            first_q       <= first_d;
            acc_q         <= acc_d;
            scale_q       <= scale_d;
            ovf_q         <= ovf_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_dp_ready  = (state_q == RUN) && (rem_q != '0);
    assign o_res_valid = (state_q == DONE);
    assign o_res       = acc_q;
    assign o_res_scale = scale_q;
    assign o_ovf       = ovf_q;

endmodule
